// File: rtl/iob_asym_stream_conv_pkg.sv
// Width helpers and shared types for the asymmetric stream width converter.
package iob_asym_stream_conv_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } dn_state_t;

    function automatic int iob_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int iob_min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int iob_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iob_stream_reg_slice.sv
// Valid/ready output register; data, keep and last only change when a new beat loads.
module iob_stream_reg_slice #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              cke,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (cke) begin
            if (in_valid && in_ready) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_keep  <= in_keep;
                out_last  <= in_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iob_asym_stream_conv.sv
// Stream width converter: packs narrow lanes into wide words, splits wide words into
// narrow lanes, or acts as a plain register slice when both widths match.
module iob_asym_stream_conv
    import iob_asym_stream_conv_pkg::*;
#(
    parameter int  I_DATA_W = 8,
    parameter int  O_DATA_W = 32,
    localparam int MIN_W    = iob_min(I_DATA_W, O_DATA_W),
    localparam int MAX_W    = iob_max(I_DATA_W, O_DATA_W),
    localparam int R        = MAX_W / MIN_W,
    localparam int I_KEEP_W = I_DATA_W / MIN_W,
    localparam int O_KEEP_W = O_DATA_W / MIN_W
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_n_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [I_DATA_W-1:0] s_data_i,
    input  logic [I_KEEP_W-1:0] s_keep_i,
    input  logic                s_last_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [O_DATA_W-1:0] m_data_o,
    output logic [O_KEEP_W-1:0] m_keep_o,
    output logic                m_last_o
);

    if (I_DATA_W < O_DATA_W) begin : g_upsize
        localparam int IDX_W = iob_clog2(R);

        logic [O_DATA_W-1:0] acc, acc_nxt;
        logic [R-1:0]        acc_keep, acc_keep_nxt;
        logic [IDX_W-1:0]    idx;
        logic                closing, accept, slice_ready;

        // A keep=0 beat only closes the word if it carries last and lanes are already filled.
        assign closing   = s_keep_i[0] ? ((idx == IDX_W'(R - 1)) || s_last_i)
                                       : (s_last_i && (idx != '0));
        assign s_ready_o = rst_n_i && (!closing || slice_ready);
        assign accept    = s_valid_i && s_ready_o;

        always_comb begin
            acc_nxt      = acc;
            acc_keep_nxt = acc_keep;
            for (int l = 0; l < R; l++) begin
                if (s_keep_i[0] && (idx == IDX_W'(l))) begin
                    acc_nxt[l*I_DATA_W +: I_DATA_W] = s_data_i;
                    acc_keep_nxt[l]                 = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                acc      <= '0;
                acc_keep <= '0;
                idx      <= '0;
            end else if (cke_i && accept) begin
                if (closing) begin
                    acc      <= '0;
                    acc_keep <= '0;
                    idx      <= '0;
                end else begin
                    acc      <= acc_nxt;
                    acc_keep <= acc_keep_nxt;
                    if (s_keep_i[0]) idx <= idx + IDX_W'(1);
                end
            end
        end

        iob_stream_reg_slice #(.DATA_W(O_DATA_W), .KEEP_W(O_KEEP_W)) u_slice (
            .clk       (clk_i),
            .cke       (cke_i),
            .rst_n     (rst_n_i),
            .in_valid  (accept && closing),
            .in_ready  (slice_ready),
            .in_data   (acc_nxt),
            .in_keep   (acc_keep_nxt),
            .in_last   (s_last_i),
            .out_valid (m_valid_o),
            .out_ready (m_ready_i),
            .out_data  (m_data_o),
            .out_keep  (m_keep_o),
            .out_last  (m_last_o)
        );
    end else if (I_DATA_W > O_DATA_W) begin : g_downsize
        // state    | meaning
        // ST_EMPTY | no word held, input accepted unconditionally
        // ST_DRAIN | emitting lanes of the held word, one per m handshake
        localparam int IDX_W = iob_clog2(R);

        dn_state_t           state, state_nxt;
        logic [I_DATA_W-1:0] hold_data;
        logic [R-1:0]        hold_keep;
        logic                hold_last;
        logic [IDX_W-1:0]    idx, top_lane;
        logic                last_lane, m_hs, load;

        always_comb begin
            top_lane = '0;
            for (int l = 0; l < R; l++) begin
                if (hold_keep[l]) top_lane = IDX_W'(l);
            end
        end

        assign last_lane = (idx == top_lane);
        assign m_hs      = (state == ST_DRAIN) && m_ready_i;
        assign s_ready_o = rst_n_i && ((state == ST_EMPTY) || (last_lane && m_ready_i));
        assign load      = s_valid_i && s_ready_o && (s_keep_i != '0);

        always_ff @(posedge clk_i) begin
            if (!rst_n_i)   state <= ST_EMPTY;
            else if (cke_i) state <= state_nxt;
        end

        always_comb begin
            state_nxt = state;
            case (state)
                ST_EMPTY: if (load) state_nxt = ST_DRAIN;
                ST_DRAIN: if (m_hs && last_lane) state_nxt = load ? ST_DRAIN : ST_EMPTY;
                default:  state_nxt = ST_EMPTY;
            endcase
        end

        always_comb begin
            m_valid_o = (state == ST_DRAIN);
            m_keep_o  = {O_KEEP_W{state == ST_DRAIN}};
            m_last_o  = hold_last && last_lane && (state == ST_DRAIN);
            m_data_o  = '0;
            for (int l = 0; l < R; l++) begin
                if (idx == IDX_W'(l)) m_data_o = hold_data[l*O_DATA_W +: O_DATA_W];
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                hold_data <= '0;
                hold_keep <= '0;
                hold_last <= 1'b0;
                idx       <= '0;
            end else if (cke_i) begin
                if (load) begin
                    hold_data <= s_data_i;
                    hold_keep <= s_keep_i;
                    hold_last <= s_last_i;
                end
                if (m_hs) idx <= last_lane ? '0 : idx + IDX_W'(1);
            end
        end
    end else begin : g_same
        logic slice_ready;

        assign s_ready_o = rst_n_i && slice_ready;

        iob_stream_reg_slice #(.DATA_W(O_DATA_W), .KEEP_W(O_KEEP_W)) u_slice (
            .clk       (clk_i),
            .cke       (cke_i),
            .rst_n     (rst_n_i),
            .in_valid  (s_valid_i),
            .in_ready  (slice_ready),
            .in_data   (s_data_i),
            .in_keep   (s_keep_i),
            .in_last   (s_last_i),
            .out_valid (m_valid_o),
            .out_ready (m_ready_i),
            .out_data  (m_data_o),
            .out_keep  (m_keep_o),
            .out_last  (m_last_o)
        );
    end

endmodule

// File: tb/tb_iob_asym_stream_conv.sv
// Bench for iob_asym_stream_conv in 8->32, 32->8 and 16->16 configurations,
// checked against a lane-level reference model.
`timescale 1ns/1ps
module tb_iob_asym_stream_conv;

    localparam int M_UP = 0;
    localparam int M_DN = 1;
    localparam int M_EQ = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic cke;
    logic rst_n;

    logic        up_s_valid, up_s_ready, up_s_last, up_m_valid, up_m_ready, up_m_last;
    logic [7:0]  up_s_data;
    logic [0:0]  up_s_keep;
    logic [31:0] up_m_data;
    logic [3:0]  up_m_keep;

    logic        dn_s_valid, dn_s_ready, dn_s_last, dn_m_valid, dn_m_ready, dn_m_last;
    logic [31:0] dn_s_data;
    logic [3:0]  dn_s_keep;
    logic [7:0]  dn_m_data;
    logic [0:0]  dn_m_keep;

    logic        eq_s_valid, eq_s_ready, eq_s_last, eq_m_valid, eq_m_ready, eq_m_last;
    logic [15:0] eq_s_data, eq_m_data;
    logic [0:0]  eq_s_keep, eq_m_keep;

    always #5 clk = ~clk;

    iob_asym_stream_conv #(.I_DATA_W(8), .O_DATA_W(32)) u_up (
        .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n),
        .s_valid_i(up_s_valid), .s_ready_o(up_s_ready), .s_data_i(up_s_data),
        .s_keep_i(up_s_keep), .s_last_i(up_s_last),
        .m_valid_o(up_m_valid), .m_ready_i(up_m_ready), .m_data_o(up_m_data),
        .m_keep_o(up_m_keep), .m_last_o(up_m_last)
    );

    iob_asym_stream_conv #(.I_DATA_W(32), .O_DATA_W(8)) u_dn (
        .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n),
        .s_valid_i(dn_s_valid), .s_ready_o(dn_s_ready), .s_data_i(dn_s_data),
        .s_keep_i(dn_s_keep), .s_last_i(dn_s_last),
        .m_valid_o(dn_m_valid), .m_ready_i(dn_m_ready), .m_data_o(dn_m_data),
        .m_keep_o(dn_m_keep), .m_last_o(dn_m_last)
    );

    iob_asym_stream_conv #(.I_DATA_W(16), .O_DATA_W(16)) u_eq (
        .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n),
        .s_valid_i(eq_s_valid), .s_ready_o(eq_s_ready), .s_data_i(eq_s_data),
        .s_keep_i(eq_s_keep), .s_last_i(eq_s_last),
        .m_valid_o(eq_m_valid), .m_ready_i(eq_m_ready), .m_data_o(eq_m_data),
        .m_keep_o(eq_m_keep), .m_last_o(eq_m_last)
    );

    beat_t src_q[$];
    beat_t stim_q[$];
    beat_t out_q[$];
    beat_t exp_q[$];
    int    acc_cyc[$];
    int    out_cyc[$];
    int    unstable;
    bit    timed_out;
    int    pass_cnt = 0;
    int    total_cnt = 0;

    task automatic idle_inputs();
        up_s_valid = 0; up_s_data = '0; up_s_keep = '0; up_s_last = 0; up_m_ready = 0;
        dn_s_valid = 0; dn_s_data = '0; dn_s_keep = '0; dn_s_last = 0; dn_m_ready = 0;
        eq_s_valid = 0; eq_s_data = '0; eq_s_keep = '0; eq_s_last = 0; eq_m_ready = 0;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d; b.keep = k; b.last = l;
        src_q.push_back(b);
    endtask

    // Feeds src_q into one DUT and records every output handshake; called at posedge+1.
    task automatic drive(input int mode, input int pv, input int pr, input int max_cyc);
        int cyc, idle;
        bit sv, sr, mv, mr, ml, pstall, pl;
        logic [31:0] md, pd;
        logic [3:0] mk, pk;
        beat_t b, o;
        cyc = 0; idle = 0; pstall = 0; pd = '0; pk = '0; pl = 0;
        out_q.delete(); acc_cyc.delete(); out_cyc.delete();
        unstable = 0; timed_out = 0;
        while (idle < 3) begin
            if (cyc >= max_cyc) begin
                timed_out = 1;
                break;
            end
            sv = (src_q.size() > 0) && ($urandom_range(99) < pv);
            mr = (src_q.size() == 0) || ($urandom_range(99) < pr);
            b = sv ? src_q[0] : '0;
            idle_inputs();
            case (mode)
                M_UP: begin
                    up_s_valid = sv; up_s_data = b.data[7:0]; up_s_keep = b.keep[0:0];
                    up_s_last = b.last; up_m_ready = mr;
                end
                M_DN: begin
                    dn_s_valid = sv; dn_s_data = b.data; dn_s_keep = b.keep;
                    dn_s_last = b.last; dn_m_ready = mr;
                end
                default: begin
                    eq_s_valid = sv; eq_s_data = b.data[15:0]; eq_s_keep = b.keep[0:0];
                    eq_s_last = b.last; eq_m_ready = mr;
                end
            endcase
            @(negedge clk);
            case (mode)
                M_UP: begin
                    sr = up_s_ready; mv = up_m_valid; md = up_m_data; mk = up_m_keep; ml = up_m_last;
                end
                M_DN: begin
                    sr = dn_s_ready; mv = dn_m_valid; md = {24'h0, dn_m_data};
                    mk = {3'b0, dn_m_keep}; ml = dn_m_last;
                end
                default: begin
                    sr = eq_s_ready; mv = eq_m_valid; md = {16'h0, eq_m_data};
                    mk = {3'b0, eq_m_keep}; ml = eq_m_last;
                end
            endcase
            if (pstall && (!mv || md !== pd || mk !== pk || ml !== pl)) unstable++;
            pstall = mv && !mr; pd = md; pk = mk; pl = ml;
            if (sv && sr) begin
                void'(src_q.pop_front());
                acc_cyc.push_back(cyc);
            end
            if (mv && mr) begin
                o.data = md; o.keep = mk; o.last = ml;
                out_q.push_back(o);
                out_cyc.push_back(cyc);
            end
            if (src_q.size() == 0 && !mv) idle++;
            else idle = 0;
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
    endtask

    // Reference: upsizing packs kept lanes until four are held or last closes;
    // downsizing emits each kept lane in order; same width forwards beats unchanged.
    function automatic void build_expected(input int mode);
        beat_t b, e;
        logic [31:0] word;
        int n;
        exp_q.delete();
        word = '0; n = 0;
        foreach (stim_q[i]) begin
            b = stim_q[i];
            if (mode == M_UP) begin
                if (b.keep[0]) begin
                    word = word | ((b.data & 32'hFF) << (8 * n));
                    n++;
                end
                if (n == 4 || (b.last && n > 0)) begin
                    e.data = word; e.keep = 4'((1 << n) - 1); e.last = b.last;
                    exp_q.push_back(e);
                    word = '0; n = 0;
                end
            end else if (mode == M_DN) begin
                n = 0;
                for (int l = 0; l < 4; l++) if (b.keep[l]) n = l + 1;
                for (int l = 0; l < n; l++) begin
                    e.data = (b.data >> (8 * l)) & 32'hFF; e.keep = 4'h1;
                    e.last = b.last && (l == n - 1);
                    exp_q.push_back(e);
                end
            end else begin
                e.data = b.data & 32'hFFFF; e.keep = b.keep & 4'h1; e.last = b.last;
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic test_reset();
        logic [15:0] got;
        idle_inputs();
        cke = 1; rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        got = {up_m_valid, up_m_last, up_s_ready, dn_m_valid, dn_m_last, dn_s_ready, dn_m_keep,
               eq_m_valid, eq_m_last, eq_s_ready, eq_m_keep, 5'b0};
        total_cnt++;
        if (got !== 16'h0) $display("FAIL reset_ctrl got=%h exp=0000", got);
        else pass_cnt++;
        total_cnt++;
        if (up_m_data !== 32'h0 || up_m_keep !== 4'h0)
            $display("FAIL reset_up_data got=%h/%h exp=0/0", up_m_data, up_m_keep);
        else pass_cnt++;
        total_cnt++;
        if (dn_m_data !== 8'h0) $display("FAIL reset_dn_data got=%h exp=00", dn_m_data);
        else pass_cnt++;
        total_cnt++;
        if (eq_m_data !== 16'h0) $display("FAIL reset_eq_data got=%h exp=0000", eq_m_data);
        else pass_cnt++;
        rst_n = 1;
        @(posedge clk); #1;
        total_cnt++;
        if ({up_s_ready, dn_s_ready, eq_s_ready} !== 3'b111)
            $display("FAIL ready_after_reset got=%b exp=111", {up_s_ready, dn_s_ready, eq_s_ready});
        else pass_cnt++;
    endtask

    task automatic test_up_full();
        beat_t e;
        int lat;
        src_q.delete();
        push(32'h11, 4'h1, 0); push(32'h22, 4'h1, 0); push(32'h33, 4'h1, 0); push(32'h44, 4'h1, 0);
        drive(M_UP, 100, 100, 200);
        e = {32'h44332211, 4'hF, 1'b0};
        total_cnt++;
        if (out_q.size() != 1) $display("FAIL up_full_count got=%0d exp=1", out_q.size());
        else pass_cnt++;
        total_cnt++;
        if (out_q.size() < 1 || out_q[0] !== e)
            $display("FAIL up_full_word got=%h exp=%h", (out_q.size() > 0) ? out_q[0] : '0, e);
        else pass_cnt++;
        lat = (out_cyc.size() > 0 && acc_cyc.size() > 3) ? out_cyc[0] - acc_cyc[3] : -1;
        total_cnt++;
        if (lat != 1) $display("FAIL up_latency got=%0d exp=1", lat);
        else pass_cnt++;
    endtask

    task automatic test_up_partial();
        beat_t e0, e1;
        src_q.delete();
        push(32'hAA, 4'h1, 0); push(32'hBB, 4'h1, 1);
        push(32'hC1, 4'h1, 0); push(32'hC2, 4'h1, 0); push(32'hC3, 4'h1, 0); push(32'hC4, 4'h1, 0);
        drive(M_UP, 100, 100, 200);
        e0 = {32'h0000BBAA, 4'h3, 1'b1};
        e1 = {32'hC4C3C2C1, 4'hF, 1'b0};
        total_cnt++;
        if (out_q.size() != 2) $display("FAIL up_partial_count got=%0d exp=2", out_q.size());
        else pass_cnt++;
        total_cnt++;
        if (out_q.size() < 2 || out_q[0] !== e0 || out_q[1] !== e1)
            $display("FAIL up_partial_words got=%h,%h exp=%h,%h",
                     (out_q.size() > 0) ? out_q[0] : '0, (out_q.size() > 1) ? out_q[1] : '0, e0, e1);
        else pass_cnt++;
    endtask

    task automatic test_dn_back_to_back();
        logic [7:0] exp_d [8];
        int gaps;
        exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        src_q.delete();
        push(32'hDDCCBBAA, 4'hF, 1); push(32'h44332211, 4'hF, 0);
        drive(M_DN, 100, 100, 200);
        total_cnt++;
        if (out_q.size() != 8) $display("FAIL dn_b2b_count got=%0d exp=8", out_q.size());
        else pass_cnt++;
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            total_cnt++;
            if (out_q[i] !== {24'h0, exp_d[i], 4'h1, (i == 3)})
                $display("FAIL dn_b2b_beat%0d got=%h exp=%h", i, out_q[i], {24'h0, exp_d[i], 4'h1, (i == 3)});
            else pass_cnt++;
        end
        gaps = 0;
        for (int i = 1; i < out_cyc.size(); i++) if (out_cyc[i] - out_cyc[i-1] != 1) gaps++;
        if (out_cyc.size() == 0 || acc_cyc.size() == 0 || out_cyc[0] - acc_cyc[0] != 1) gaps++;
        total_cnt++;
        if (gaps != 0) $display("FAIL dn_no_bubble got=%0d gaps exp=0", gaps);
        else pass_cnt++;
    endtask

    task automatic test_dn_keep();
        beat_t e [3];
        e[0] = {32'hAA, 4'h1, 1'b0};
        e[1] = {32'hBB, 4'h1, 1'b1};
        e[2] = {32'hCC, 4'h1, 1'b1};
        src_q.delete();
        push(32'h9988BBAA, 4'h3, 1); push(32'h12345678, 4'h0, 0); push(32'h777766CC, 4'h1, 1);
        drive(M_DN, 100, 100, 200);
        total_cnt++;
        if (out_q.size() != 3) $display("FAIL dn_keep_count got=%0d exp=3", out_q.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            total_cnt++;
            if (out_q[i] !== e[i]) $display("FAIL dn_keep_beat%0d got=%h exp=%h", i, out_q[i], e[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_cke_freeze();
        idle_inputs();
        dn_s_valid = 1; dn_s_data = 32'hDDCCBBAA; dn_s_keep = 4'hF; dn_s_last = 0;
        @(posedge clk); #1;
        dn_s_valid = 0;
        cke = 0; dn_m_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({dn_m_valid, dn_m_data} !== {1'b1, 8'hAA})
            $display("FAIL cke_hold got=%b/%h exp=1/aa", dn_m_valid, dn_m_data);
        else pass_cnt++;
        cke = 1;
        @(posedge clk); #1;
        total_cnt++;
        if ({dn_m_valid, dn_m_data} !== {1'b1, 8'hBB})
            $display("FAIL cke_resume got=%b/%h exp=1/bb", dn_m_valid, dn_m_data);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (dn_m_valid !== 1'b0) $display("FAIL cke_drain got=%b exp=0", dn_m_valid);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] bytes [6];
        beat_t e;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            up_s_valid = 1; up_s_data = bytes[i]; up_s_keep = 1'b1;
            @(posedge clk); #1;
        end
        up_s_valid = 0;
        total_cnt++;
        if ({up_m_valid, up_m_data} !== {1'b1, 32'h44332211})
            $display("FAIL mid_stall_word got=%b/%h exp=1/44332211", up_m_valid, up_m_data);
        else pass_cnt++;
        rst_n = 0;
        @(posedge clk); #1;
        total_cnt++;
        if ({up_m_valid, up_m_data, up_m_keep, up_m_last, up_s_ready} !== 39'h0)
            $display("FAIL mid_reset_outputs got=%h exp=0",
                     {up_m_valid, up_m_data, up_m_keep, up_m_last, up_s_ready});
        else pass_cnt++;
        rst_n = 1;
        src_q.delete();
        push(32'hA1, 4'h1, 0); push(32'hA2, 4'h1, 0); push(32'hA3, 4'h1, 0); push(32'hA4, 4'h1, 0);
        drive(M_UP, 100, 100, 200);
        e = {32'hA4A3A2A1, 4'hF, 1'b0};
        total_cnt++;
        if (out_q.size() != 1 || out_q[0] !== e)
            $display("FAIL mid_clean_word got=%0d beats first=%h exp=1 beat %h",
                     out_q.size(), (out_q.size() > 0) ? out_q[0] : '0, e);
        else pass_cnt++;
    endtask

    task automatic test_random(input int mode);
        beat_t b;
        int n;
        src_q.delete();
        for (int i = 0; i < 1000; i++) begin
            b.data = $urandom;
            b.last = ($urandom_range(7) == 0);
            if (mode == M_DN) begin
                n = ($urandom_range(15) == 0) ? 0 : $urandom_range(4, 1);
                b.keep = 4'((1 << n) - 1);
            end else begin
                b.keep = {3'b0, ($urandom_range(9) != 0)};
            end
            if (mode == M_UP) b.data = b.data & 32'hFF;
            if (mode == M_EQ) b.data = b.data & 32'hFFFF;
            if (i == 999) begin
                b.last = 1;
                b.keep = (mode == M_DN) ? 4'hF : 4'h1;
            end
            src_q.push_back(b);
        end
        stim_q = src_q;
        build_expected(mode);
        drive(mode, 70, 60, 20000);
        total_cnt++;
        if (timed_out) $display("FAIL rand_m%0d_timeout got=%0d left exp=0", mode, src_q.size());
        else pass_cnt++;
        total_cnt++;
        if (out_q.size() != exp_q.size())
            $display("FAIL rand_m%0d_count got=%0d exp=%0d", mode, out_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            total_cnt++;
            if (out_q[i] !== exp_q[i])
                $display("FAIL rand_m%0d_beat%0d got=%h exp=%h", mode, i, out_q[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (unstable != 0) $display("FAIL rand_m%0d_stall_stable got=%0d changes exp=0", mode, unstable);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_up_full();
        test_up_partial();
        test_dn_back_to_back();
        test_dn_keep();
        test_cke_freeze();
        test_reset_mid_packet();
        test_random(M_UP);
        test_random(M_DN);
        test_random(M_EQ);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
